bsg_gray_ptr_tx: RTL
====================

// Module: bsg_gray_ptr_tx
// PURPOSE
//  Source-side pointer generator for Gray-coded clock-domain crossings: keeps a binary
//  pointer and publishes a registered Gray copy for a far-domain synchronizer, whose
//  output the existing Gray-to-binary scan block decodes.
//  Optional hold window keeps each Gray code stable long enough for slow receivers.
//  Used as the write/read pointer source of async FIFOs and credit counters.
// PARAMETERS
//  width_p        16  pointer width in bits; >= 2
//  hold_cycles_p   0  extra cycles ready_o stays low after each pointer change; 0 = none
// PORTS
//  clk_i            in   1        clock
//  reset_i          in   1        synchronous, active-high reset
//  v_i              in   1        increment request
//  ready_o          out  1        increment accepted this cycle when v_i & ready_o
//  load_v_i         in   1        load request; always accepted; priority over v_i
//  load_binary_i    in   width_p  binary value to load
//  ptr_binary_o     out  width_p  current binary pointer (registered)
//  ptr_binary_n_o   out  width_p  binary pointer value for next cycle (combinational)
//  ptr_gray_o       out  width_p  registered Gray code of ptr_binary_o; straight from flops
//  wrap_o           out  1        1-cycle pulse on the cycle after pointer wraps max -> 0
// BEHAVIOUR
//  - Reset: ptr_binary_o=0, ptr_gray_o=0, wrap_o=0, hold counter=0, ready_o=1.
//    Reset overrides load_v_i and v_i in the same cycle.
//  - Gray encoding: gray = b ^ (b >> 1), computed on ptr_binary_n_o.
//    Registered into ptr_gray_o with no glitchable logic after the flop.
//  - Increment: v_i & ready_o at edge t -> ptr_binary_o, ptr_gray_o show +1 from t+1.
//    Exactly one Gray bit changes per increment.
//  - Wrap: binary (2^width_p)-1 -> 0, mod 2^width_p; Gray 100..0 -> 000..0.
//    wrap_o high for exactly the cycle the new value 0 is presented.
//  - Load: load_v_i at edge t -> ptr_binary_o=load_binary_i, ptr_gray_o=its Gray from t+1.
//    Any v_i that cycle is dropped; it is not queued.
//    ready_o is driven 0 combinationally while load_v_i=1, so the dropped v_i is not a
//    handshake. Multiple Gray bits may change; caller guarantees the receiver tolerates it.
//    A load never asserts wrap_o.
//  - Hold FSM, states READY / HOLD:
//    READY: ready_o=1 unless load_v_i=1.
//      On an accepted increment or a load, if hold_cycles_p>0, go to HOLD with
//      counter=hold_cycles_p.
//    HOLD: ready_o=0. Counter decrements each cycle; at 1 -> READY.
//      A load in HOLD updates the pointer and restarts counter=hold_cycles_p.
//    hold_cycles_p=0: FSM degenerates, ready_o = ~load_v_i; full rate 1 increment/cycle.
//  - Counter width = $clog2(hold_cycles_p+1), minimum 1.
//  - Reset mid-HOLD returns to READY with pointer 0 on the next cycle.
// STRUCTURE
//  - No shared-package typedefs; FSM state encoding is local to this module.
//  - One combinational sub-module: bsg_binary_to_gray #(width_p), ports binary_i,
//    gray_o; implements b ^ (b >> 1); reused by other pointer sources.
//  - Top holds binary reg, Gray reg, hold counter and FSM, and the wrap_o flop.
// TESTING
//  - Reset, width_p=4: reset_i=1 for 2 cycles, v_i=1 -> ptr 0, gray 0000, ready_o=1,
//    wrap_o=0; no increment while reset.
//  - Count, width_p=4, hold=0: v_i=1 for 5 cycles -> gray 0001,0011,0010,0110,0111,
//    one increment per cycle.
//  - Wrap: load 14, then v_i x2 -> gray 1001, 1000, then 0000.
//    wrap_o=1 only with 0000; a scoreboard checks 1 Gray bit flips per increment.
//  - Hold, hold=2: v_i held 1 -> increments at cycles 0,3,6.
//    ready_o pattern 1,0,0,1,0,0,...
//  - Load priority: load_v_i=1, load_binary_i=9, v_i=1 same cycle in READY ->
//    ptr=9, gray 1101, no +1, ready_o=0 that cycle.
//    Load in HOLD restarts the 2-cycle hold.
//  - Reset mid-HOLD: reset_i on the 2nd HOLD cycle -> next cycle ptr=0, gray=0,
//    ready_o=1.
//    Random v_i/load stream checked against model gray == b^(b>>1) every cycle.

Source files
------------

// File: rtl/bsg_gray_ptr_tx_pkg.sv
// Shared sizing helpers for Gray pointer sources.
package bsg_gray_ptr_tx_pkg;

    // Hold counter must represent hold_cycles_p; never narrower than one bit.
    function automatic int hold_cnt_width(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bsg_binary_to_gray.sv
// Combinational binary-to-Gray encoder shared by pointer sources.
module bsg_binary_to_gray #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] binary_i,
    output logic [width_p-1:0] gray_o
);

    assign gray_o = binary_i ^ (binary_i >> 1);

endmodule

// File: rtl/bsg_gray_ptr_tx.sv
// Source-side pointer for Gray-coded CDC: binary pointer, registered Gray copy,
// wrap pulse and an optional hold window throttling increments.
module bsg_gray_ptr_tx
    import bsg_gray_ptr_tx_pkg::*;
#(
    parameter int width_p       = 16,
    parameter int hold_cycles_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic               load_v_i,
    input  logic [width_p-1:0] load_binary_i,
    output logic [width_p-1:0] ptr_binary_o,
    output logic [width_p-1:0] ptr_binary_n_o,
    output logic [width_p-1:0] ptr_gray_o,
    output logic               wrap_o
);

    localparam int cnt_w_lp = hold_cnt_width(hold_cycles_p);
    localparam logic [cnt_w_lp-1:0] hold_init_lp = cnt_w_lp'(hold_cycles_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp   = cnt_w_lp'(1);
    localparam logic [width_p-1:0]  ptr_one_lp   = width_p'(1);

    typedef enum logic {eREADY, eHOLD} state_e;

    state_e               state_q, state_d;
    logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
    logic [width_p-1:0]   ptr_q, ptr_d;
    logic [width_p-1:0]   gray_q, gray_d;
    logic                 wrap_q, wrap_d;
    logic                 accept_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        case (state_q)
            eREADY: ready_o = ~load_v_i;
            eHOLD:  ready_o = 1'b0;
            default: ready_o = 1'b0;
        endcase

        accept_inc = v_i & ready_o;

        if (hold_cycles_p > 0) begin
            case (state_q)
                eREADY: begin
                    if (load_v_i | accept_inc) begin
                        state_d = eHOLD;
                        cnt_d   = hold_init_lp;
                    end
                end
                eHOLD: begin
                    // A load restarts the window so its multi-bit change also gets a full hold.
                    if (load_v_i) begin
                        cnt_d = hold_init_lp;
                    end else if (cnt_q == cnt_one_lp) begin
                        state_d = eREADY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - cnt_one_lp;
                    end
                end
                default: begin
                    state_d = eREADY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load_v_i) begin
            ptr_d = load_binary_i;
        end else if (accept_inc) begin
            ptr_d = ptr_q + ptr_one_lp;
        end
        wrap_d = accept_inc & ~load_v_i & (ptr_q == {width_p{1'b1}});
    end

    assign ptr_binary_n_o = ptr_d;

    bsg_binary_to_gray #(.width_p(width_p)) b2g (
        .binary_i (ptr_d),
        .gray_o   (gray_d)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eREADY;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gray_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gray_q  <= gray_d;
            wrap_q  <= wrap_d;
        end
    end

    // Gray output comes straight from its flop so the far domain never samples a glitch.
    assign ptr_binary_o = ptr_q;
    assign ptr_gray_o   = gray_q;
    assign wrap_o       = wrap_q;

endmodule
